// File: rtl/bitserial_pkg.sv
// bitserial_pkg: shared types and defaults for the bit-serial datapath and its decoder
//   WIDTH_DEF : default data width of the accumulator, operand register and switch word
//   region_e  : which shift register the GPR strobes address (A or B)
//   src_e     : serial source select (accumulator LSB or a switch bit)
//   alu_e     : serial ALU mode (full add or pass-through)
package bitserial_pkg;
   localparam int WIDTH_DEF = 8;
   typedef enum logic {REG_A = 1'b0, REG_B = 1'b1} region_e;
   typedef enum logic {SRC_ACC = 1'b0, SRC_SW = 1'b1} src_e;
   typedef enum logic {ALU_ADD = 1'b0, ALU_PASS = 1'b1} alu_e;
   function automatic logic maj(input logic x, input logic y, input logic z);
      return (x & y) | (x & z) | (y & z);
   endfunction
endpackage

// File: rtl/serial_adder_bit.sv
// serial_adder_bit: combinational one-bit full adder for the serial datapath
//   a, b, ci : addend bits and incoming carry
//   s        : sum bit
//   co       : carry-out (majority of the three inputs)
module serial_adder_bit
   import bitserial_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = maj(a, b, ci);
endmodule

// File: rtl/bitserial_datapath.sv
// bitserial_datapath: LSB-first bit-serial accumulator/operand datapath with serial adder
//   i_clk, i_rst_n   : clock and synchronous active-low reset
//   i_switches       : switch word sampled one bit per cycle during Load
//   i_con_mux8       : index of the switch bit presented this cycle
//   i_con_mux        : source select (1 = switch bit, 0 = A[0])
//   i_con_muxalu     : ALU select (1 = pass source, 0 = add)
//   i_con_gpr_region : shifted region (0 = A, 1 = B)
//   i_con_gpr_write  : region A only, 1 = shift in ALU bit, 0 = rotate
//   i_con_gpr_shift  : shift enable for the selected region
//   i_con_pcincr     : instruction-complete strobe, clears the carry
//   o_acc, o_regb    : accumulator A and operand B
//   o_cout           : carry-out of the last completed add
//   o_busy_bit       : current serial ALU bit
module bitserial_datapath
   import bitserial_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int SELW  = $clog2(WIDTH)
)
(
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_switches,
   input  logic [SELW-1:0]  i_con_mux8,
   input  logic             i_con_mux,
   input  logic             i_con_muxalu,
   input  logic             i_con_gpr_region,
   input  logic             i_con_gpr_write,
   input  logic             i_con_gpr_shift,
   input  logic             i_con_pcincr,
   output logic [WIDTH-1:0] o_acc,
   output logic [WIDTH-1:0] o_regb,
   output logic             o_cout,
   output logic             o_busy_bit
);
   logic [WIDTH-1:0] acc, regb, acc_n, regb_n, sw_shift;
   logic carry, carry_n, cout_n, src, sum, cy_n, alu_bit, add_shift;
   region_e region;
   src_e    src_sel;
   alu_e    alu_sel;

   assign region  = region_e'(i_con_gpr_region);
   assign src_sel = src_e'(i_con_mux);
   assign alu_sel = alu_e'(i_con_muxalu);

   // Shifting instead of indexing makes an out-of-range select read as 0.
   assign sw_shift = i_switches >> i_con_mux8;
   assign src      = (src_sel == SRC_SW) ? sw_shift[0] : acc[0];

   serial_adder_bit u_add (
      .a  (src),
      .b  (regb[0]),
      .ci (carry),
      .s  (sum),
      .co (cy_n)
   );

   assign alu_bit    = (alu_sel == ALU_PASS) ? src : sum;
   assign o_busy_bit = alu_bit;
   assign add_shift  = i_con_gpr_shift && region == REG_A && i_con_gpr_write && alu_sel == ALU_ADD;

   // The non-selected register rotates while the other one shifts, so a full
   // WIDTH-cycle pass leaves it as it was.
   always_comb begin
      acc_n   = acc;
      regb_n  = regb;
      if (i_con_gpr_shift) begin
         acc_n  = (region == REG_A && i_con_gpr_write) ? {alu_bit, acc[WIDTH-1:1]} : {acc[0], acc[WIDTH-1:1]};
         regb_n = (region == REG_B) ? {alu_bit, regb[WIDTH-1:1]} :
                  i_con_gpr_write   ? {regb[0], regb[WIDTH-1:1]} : regb;
      end
      carry_n = (i_con_pcincr || (i_con_gpr_shift && alu_sel == ALU_PASS)) ? 1'b0 :
                add_shift ? cy_n : carry;
      // The last add bit coincides with pcincr; latch its carry before the clear.
      cout_n  = (i_con_pcincr && add_shift) ? cy_n : o_cout;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         acc    <= '0;
         regb   <= '0;
         carry  <= 1'b0;
         o_cout <= 1'b0;
      end else begin
         acc    <= acc_n;
         regb   <= regb_n;
         carry  <= carry_n;
         o_cout <= cout_n;
      end
   end

   assign o_acc  = acc;
   assign o_regb = regb;
endmodule

// File: tb/tb_bitserial_datapath.sv
// tb_bitserial_datapath: directed self-checking bench for bitserial_datapath
module tb_bitserial_datapath;
   logic       i_clk = 1'b0;
   logic       i_rst_n;
   logic [7:0] i_switches;
   logic [2:0] i_con_mux8;
   logic       i_con_mux, i_con_muxalu, i_con_gpr_region, i_con_gpr_write, i_con_gpr_shift, i_con_pcincr;
   logic [7:0] o_acc, o_regb;
   logic       o_cout, o_busy_bit;
   int total = 0;
   int bad = 0;

   bitserial_datapath dut (
      .i_clk            (i_clk),
      .i_rst_n          (i_rst_n),
      .i_switches       (i_switches),
      .i_con_mux8       (i_con_mux8),
      .i_con_mux        (i_con_mux),
      .i_con_muxalu     (i_con_muxalu),
      .i_con_gpr_region (i_con_gpr_region),
      .i_con_gpr_write  (i_con_gpr_write),
      .i_con_gpr_shift  (i_con_gpr_shift),
      .i_con_pcincr     (i_con_pcincr),
      .o_acc            (o_acc),
      .o_regb           (o_regb),
      .o_cout           (o_cout),
      .o_busy_bit       (o_busy_bit)
   );

   always #5 i_clk = ~i_clk;

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic idle();
      i_rst_n = 1'b1; i_con_mux8 = 3'd0; i_con_mux = 1'b0; i_con_muxalu = 1'b0;
      i_con_gpr_region = 1'b0; i_con_gpr_write = 1'b0; i_con_gpr_shift = 1'b0; i_con_pcincr = 1'b0;
   endtask

   task automatic do_load(input logic [7:0] sw);
      i_switches = sw; i_con_mux = 1'b1; i_con_muxalu = 1'b1;
      i_con_gpr_region = 1'b0; i_con_gpr_write = 1'b1; i_con_gpr_shift = 1'b1;
      for (int i = 0; i < 8; i++) begin
         i_con_mux8 = 3'(i); i_con_pcincr = (i == 7); tick();
      end
      idle();
   endtask

   task automatic do_copy();
      i_con_mux = 1'b0; i_con_muxalu = 1'b1; i_con_gpr_region = 1'b1; i_con_gpr_shift = 1'b1;
      for (int i = 0; i < 8; i++) begin
         i_con_pcincr = (i == 7); tick();
      end
      idle();
   endtask

   task automatic do_add(input int n);
      i_con_mux = 1'b0; i_con_muxalu = 1'b0; i_con_gpr_region = 1'b0; i_con_gpr_write = 1'b1; i_con_gpr_shift = 1'b1;
      for (int i = 0; i < n; i++) begin
         i_con_pcincr = (i == 7); tick();
      end
      idle();
   endtask

   task automatic test_reset();
      idle();
      i_rst_n = 1'b0; i_con_gpr_shift = 1'b1; i_con_gpr_write = 1'b1; i_con_mux = 1'b1; i_switches = 8'hFF;
      repeat (3) tick();
      idle();
      total++; if (o_acc !== 8'h00) begin bad++; $display("FAIL reset_acc got=%h want=00", o_acc); end
      total++; if (o_regb !== 8'h00) begin bad++; $display("FAIL reset_regb got=%h want=00", o_regb); end
      total++; if (o_cout !== 1'b0) begin bad++; $display("FAIL reset_cout got=%b want=0", o_cout); end
   endtask

   task automatic test_load();
      do_load(8'hA5);
      total++; if (o_acc !== 8'hA5) begin bad++; $display("FAIL load_acc got=%h want=a5", o_acc); end
      total++; if (o_regb !== 8'h00) begin bad++; $display("FAIL load_regb got=%h want=00", o_regb); end
      total++; if (o_cout !== 1'b0) begin bad++; $display("FAIL load_cout got=%b want=0", o_cout); end
   endtask

   task automatic test_copy();
      do_load(8'h3C);
      do_copy();
      total++; if (o_regb !== 8'h3C) begin bad++; $display("FAIL copy_regb got=%h want=3c", o_regb); end
      total++; if (o_acc !== 8'h3C) begin bad++; $display("FAIL copy_acc got=%h want=3c", o_acc); end
      total++; if (dut.carry !== 1'b0) begin bad++; $display("FAIL copy_carry got=%b want=0", dut.carry); end
   endtask

   task automatic test_add_no_ovf();
      do_add(8);
      total++; if (o_acc !== 8'h78) begin bad++; $display("FAIL add_acc got=%h want=78", o_acc); end
      total++; if (o_cout !== 1'b0) begin bad++; $display("FAIL add_cout got=%b want=0", o_cout); end
      total++; if (o_regb !== 8'h3C) begin bad++; $display("FAIL add_regb got=%h want=3c", o_regb); end
   endtask

   task automatic test_add_ovf();
      do_load(8'hC8);
      do_copy();
      do_add(8);
      total++; if (o_acc !== 8'h90) begin bad++; $display("FAIL ovf_acc got=%h want=90", o_acc); end
      total++; if (o_cout !== 1'b1) begin bad++; $display("FAIL ovf_cout got=%b want=1", o_cout); end
      total++; if (dut.carry !== 1'b0) begin bad++; $display("FAIL ovf_carry got=%b want=0", dut.carry); end
   endtask

   task automatic test_rotate_hold();
      i_con_gpr_region = 1'b0; i_con_gpr_write = 1'b0; i_con_gpr_shift = 1'b1;
      repeat (2) tick();
      total++; if (o_acc !== 8'h24) begin bad++; $display("FAIL rot_acc got=%h want=24", o_acc); end
      total++; if (o_regb !== 8'hC8) begin bad++; $display("FAIL rot_regb got=%h want=c8", o_regb); end
      repeat (6) tick();
      total++; if (o_acc !== 8'h90) begin bad++; $display("FAIL rot_back_acc got=%h want=90", o_acc); end
      idle();
      i_con_pcincr = 1'b1; i_con_gpr_write = 1'b1; i_con_mux = 1'b1; tick();
      i_con_gpr_region = 1'b1; tick();
      idle();
      total++; if (o_acc !== 8'h90) begin bad++; $display("FAIL hold_acc got=%h want=90", o_acc); end
      total++; if (o_regb !== 8'hC8) begin bad++; $display("FAIL hold_regb got=%h want=c8", o_regb); end
      total++; if (o_cout !== 1'b1) begin bad++; $display("FAIL hold_cout got=%b want=1", o_cout); end
   endtask

   task automatic test_busy_bit();
      i_switches = 8'h04; i_con_mux = 1'b1; i_con_mux8 = 3'd2; i_con_muxalu = 1'b1; #1;
      total++; if (o_busy_bit !== 1'b1) begin bad++; $display("FAIL busy_pass got=%b want=1", o_busy_bit); end
      i_con_mux8 = 3'd3; #1;
      total++; if (o_busy_bit !== 1'b0) begin bad++; $display("FAIL busy_pass0 got=%b want=0", o_busy_bit); end
      i_con_mux8 = 3'd2; i_con_muxalu = 1'b0; #1;
      total++; if (o_busy_bit !== 1'b1) begin bad++; $display("FAIL busy_sum got=%b want=1", o_busy_bit); end
      i_con_mux = 1'b0; i_con_mux8 = 3'd0; i_switches = 8'h00; #1;
      total++; if (o_busy_bit !== 1'b0) begin bad++; $display("FAIL busy_acc got=%b want=0", o_busy_bit); end
      idle();
   endtask

   task automatic test_reset_mid_add();
      do_load(8'hFF);
      do_copy();
      do_add(4);
      total++; if (dut.carry !== 1'b1) begin bad++; $display("FAIL mid_carry got=%b want=1", dut.carry); end
      i_rst_n = 1'b0; i_con_gpr_shift = 1'b1; i_con_gpr_write = 1'b1; tick();
      idle();
      total++; if (o_acc !== 8'h00) begin bad++; $display("FAIL mid_rst_acc got=%h want=00", o_acc); end
      total++; if (o_cout !== 1'b0) begin bad++; $display("FAIL mid_rst_cout got=%b want=0", o_cout); end
      do_load(8'h0F);
      total++; if (o_acc !== 8'h0F) begin bad++; $display("FAIL mid_load_acc got=%h want=0f", o_acc); end
      total++; if (o_cout !== 1'b0) begin bad++; $display("FAIL mid_load_cout got=%b want=0", o_cout); end
      total++; if (o_regb !== 8'h00) begin bad++; $display("FAIL mid_load_regb got=%h want=00", o_regb); end
   endtask

   task automatic test_back_to_back();
      do_copy();
      do_add(8);
      total++; if (o_acc !== 8'h1E) begin bad++; $display("FAIL b2b_acc got=%h want=1e", o_acc); end
      total++; if (o_cout !== 1'b0) begin bad++; $display("FAIL b2b_cout got=%b want=0", o_cout); end
      do_add(8);
      total++; if (o_acc !== 8'h2D) begin bad++; $display("FAIL b2b2_acc got=%h want=2d", o_acc); end
   endtask

   initial begin
      i_switches = 8'h00;
      idle();
      test_reset();
      test_load();
      test_copy();
      test_add_no_ovf();
      test_add_ovf();
      test_rotate_hold();
      test_busy_bit();
      test_reset_mid_add();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
